// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB writeback buffer feeding the register-file write port
//
// Two-entry FIFO between the MEMORY stage and the register file. Write data is
// resolved at capture (load data or ALU result); the head entry is presented as
// one register-file write per cycle with a valid/ready handshake.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mem_valid/mem_ready  upstream handshake from the MEMORY stage
//   mem_regwrite         instruction writes a register
//   mem_memtoreg         1 selects read_data, 0 selects mem_alu_result
//   read_data            load data
//   mem_alu_result       ALU result
//   mem_write_reg        destination register
//   flush                drop every buffered instruction
//   rf_ready             register-file write port accepts a write
//   MEM_WB_regwrite      qualified write enable (valid and rd != 0)
//   MEM_WB_rd            write address (0 when idle)
//   WB_mux5_writedata    write data (0 when idle)
//   wb_valid             head entry is valid
//   retire_count         retired-instruction counter, wraps modulo 2^CNT_W
//
// Optional feature macro: WB_BYPASS_EN (zero-cycle bypass when the buffer is empty).

module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [REG_AW-1:0] mem_write_reg,
    input  logic              flush,
    input  logic              rf_ready,
    output logic              MEM_WB_regwrite,
    output logic [REG_AW-1:0] MEM_WB_rd,
    output logic [DATA_W-1:0] WB_mux5_writedata,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retire_count
);

    logic [1:0]        count;
    logic              head;
    logic              tail;
    logic              ent_rw   [2];
    logic [REG_AW-1:0] ent_rd   [2];
    logic [DATA_W-1:0] ent_data [2];

    logic [DATA_W-1:0] in_data;
    logic              in_rw;
    logic              buf_valid;
    logic              pop;
    logic              push;
    logic              store;
    logic              buf_pop;

    assign in_data   = mem_memtoreg ? read_data : mem_alu_result;
    assign in_rw     = mem_regwrite && (mem_write_reg != '0);
    assign buf_valid = (count != 2'd0);
    assign mem_ready = (count != 2'd2);

`ifdef WB_BYPASS_EN
    logic bypass;
    assign bypass = (count == 2'd0) && mem_valid;
`endif

    always_comb begin
        wb_valid          = 1'b0;
        MEM_WB_regwrite   = 1'b0;
        MEM_WB_rd         = '0;
        WB_mux5_writedata = '0;
        if (buf_valid) begin
            wb_valid          = 1'b1;
            MEM_WB_regwrite   = ent_rw[head] && (ent_rd[head] != '0);
            MEM_WB_rd         = ent_rd[head];
            WB_mux5_writedata = ent_data[head];
        end
`ifdef WB_BYPASS_EN
        else if (bypass) begin
            wb_valid          = 1'b1;
            MEM_WB_regwrite   = in_rw;
            MEM_WB_rd         = mem_write_reg;
            WB_mux5_writedata = in_data;
        end
`endif
    end

    // Non-writing entries (regwrite=0 or rd=0) retire without waiting for rf_ready.
    assign pop     = wb_valid && (rf_ready || !MEM_WB_regwrite);
    assign push    = mem_valid && mem_ready;
    assign buf_pop = pop && buf_valid;

`ifdef WB_BYPASS_EN
    // A bypassed instruction that retires this cycle never enters the buffer.
    assign store = push && !(bypass && pop);
`else
    assign store = push;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= 2'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            retire_count <= '0;
            for (int i = 0; i < 2; i++) begin
                ent_rw[i]   <= 1'b0;
                ent_rd[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (store) begin
                ent_rw[tail]   <= mem_regwrite;
                ent_rd[tail]   <= mem_write_reg;
                ent_data[tail] <= in_data;
                tail           <= ~tail;
            end
            if (buf_pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, store} - {1'b0, buf_pop};
            if (pop) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

endmodule
